// File: rtl/dac_sample_scheduler.sv
// Buffers sigma-delta DAC samples, releases one per oversampling tick, and applies
// a linear soft-mute gain ramp on enable/disable; flags underruns while playing.
module dac_sample_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAIN_STEP  = 1
) (
  input  logic        i_clk,
  input  logic        i_res,
  input  logic [7:0]  i_osr,
  input  logic        i_enable,
  input  logic [15:0] i_sample,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [15:0] o_func,
  output logic        o_tick,
  output logic [1:0]  o_state,
  output logic        o_underrun,
  input  logic        i_clr_underrun
);

  localparam int         AW        = $clog2(FIFO_DEPTH);
  localparam logic [9:0] STEP      = 10'(GAIN_STEP);
  localparam logic [8:0] FULL_GAIN = 9'd256;

  typedef enum logic [1:0] {
    MUTED     = 2'd0,
    RAMP_UP   = 2'd1,
    PLAYING   = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [8:0]         gain_q, gain_d, gain_up, gain_dn;
  logic [9:0]         gain_sum;
  logic [7:0]         cnt_q;
  logic               tick, flush, push, pop, empty, full;
  logic [AW:0]        wr_ptr, rd_ptr;
  logic [15:0]        mem [FIFO_DEPTH];
  logic [15:0]        sample_q, sample_d, func_q;
  logic signed [24:0] product;
  logic               underrun_q;

  assign tick   = (cnt_q == 8'd0);
  assign o_tick = tick & ~i_res;

  always_ff @(posedge i_clk or posedge i_res) begin
    if (i_res)     cnt_q <= 8'd0;
    else if (tick) cnt_q <= i_osr;
    else           cnt_q <= cnt_q - 8'd1;
  end

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign o_ready = !full && (state_q != MUTED);
  assign push    = i_valid && o_ready;
  assign pop     = tick && (state_q != MUTED) && !empty;

  always_ff @(posedge i_clk or posedge i_res) begin
    if (i_res) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= i_sample;
  end

  assign gain_sum = {1'b0, gain_q} + STEP;
  assign gain_up  = (gain_sum >= 10'd256) ? FULL_GAIN : gain_sum[8:0];
  assign gain_dn  = ({1'b0, gain_q} <= STEP) ? 9'd0 : gain_q - STEP[8:0];

  // Direction follows i_enable in the same cycle, so a tick coinciding with a
  // toggle already ramps the new way.
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    flush   = 1'b0;
    case (state_q)
      MUTED: begin
        if (i_enable) state_d = RAMP_UP;
      end
      PLAYING: begin
        if (!i_enable) begin
          state_d = RAMP_DOWN;
          if (tick) begin
            gain_d = gain_dn;
            if (gain_dn == 9'd0) begin
              state_d = MUTED;
              flush   = 1'b1;
            end
          end
        end
      end
      default: begin
        if (i_enable) begin
          state_d = RAMP_UP;
          if (tick) begin
            gain_d = gain_up;
            if (gain_up == FULL_GAIN) state_d = PLAYING;
          end
        end else begin
          state_d = RAMP_DOWN;
          if (tick) begin
            gain_d = gain_dn;
            if (gain_dn == 9'd0) begin
              state_d = MUTED;
              flush   = 1'b1;
            end
          end
        end
      end
    endcase
  end

  always_comb begin
    sample_d = sample_q;
    if (flush)    sample_d = 16'd0;
    else if (pop) sample_d = mem[rd_ptr[AW-1:0]];
  end

  assign product = 25'($signed(sample_d)) * 25'($signed({1'b0, gain_d}));

  always_ff @(posedge i_clk or posedge i_res) begin
    if (i_res) begin
      state_q    <= MUTED;
      gain_q     <= 9'd0;
      sample_q   <= 16'd0;
      func_q     <= 16'd0;
      underrun_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gain_q   <= gain_d;
      sample_q <= sample_d;
      func_q   <= 16'(product >>> 8);
      if (tick && (state_q == PLAYING) && empty) underrun_q <= 1'b1;
      else if (i_clr_underrun)                   underrun_q <= 1'b0;
    end
  end

  assign o_func     = func_q;
  assign o_state    = state_q;
  assign o_underrun = underrun_q;

endmodule
